eth_tx_frame_feeder: RTL and testbench
======================================

Name: eth_tx_frame_feeder

Overview:
Store-and-forward frame buffer that sits directly upstream of the RGMII transmit MAC stage, in the tx clock domain. It accepts frame bytes from the packet source, commits complete frames to an internal byte FIFO, and then drives the MAC's start/ready/valid/data handshake for each frame. It pads short frames with 0x00 to the Ethernet minimum (60 bytes before FCS) and enforces the inter-frame holdoff so that no start strobe is lost.

Parameters:
FIFO_AW, 11, FIFO address width; depth = 2^FIFO_AW bytes (2048, which holds one maximum 1518-byte frame plus slack)
MIN_LEN, 60, minimum bytes presented per frame, excluding FCS
HOLDOFF, 17, clocks after the MAC end-of-frame cycle before the next start may be issued

Ports:
clk  in  1  tx clock (same clock as the MAC tx stage)
rst  in  1  synchronous reset, active-high
in_valid  in  1  ingress byte valid
in_ready  out  1  ingress can accept a byte
in_data  in  8  ingress byte
in_last  in  1  marks the final byte of a frame
tx_start  out  1  one-cycle start strobe to the MAC
tx_ready  in  1  MAC accept indication; a byte is consumed when tx_valid & tx_ready
tx_valid  out  1  byte available; deasserting it after the first consume ends the frame
tx_error  out  1  abort request to the MAC; driven 0 in this revision
tx_data  out  8  byte to the MAC
frames_sent  out  16  wrapping count of frames completed
frames_dropped  out  16  wrapping count of frames discarded on overflow

Behaviour:
- Reset: all outputs 0 except in_ready=1. FIFO empty, committed-frame count 0, state IDLE, holdoff counter 0, both statistics counters 0. Reset mid-frame discards everything; tx_valid drops in the next cycle.
- Ingress: a byte is written when in_valid & in_ready. A write with in_last=1 advances the commit pointer and increments the committed-frame count.
  - The read side only ever sees committed bytes.
  - in_ready = !full, except in DROP mode (see below).
- Overflow: FIFO full, committed count 0, and the current write is not the last byte ⇒ enter DROP.
  - DROP rewinds the write pointer to the commit pointer and holds in_ready=1.
  - Bytes are discarded until a byte with in_last=1 is accepted. That byte exits DROP and increments frames_dropped.
  - If the FIFO is full while committed count > 0, in_ready=0 and the source stalls normally.
- Simultaneous commit (write side) and frame-complete (read side) in one cycle: the committed count is unchanged.
- Tx state machine:
  - IDLE: wait for committed count > 0 and holdoff counter == 0. Then assert tx_start for exactly 1 cycle and go to SEND.
  - SEND: tx_valid=1, tx_data = FIFO head (first-word-fall-through). Data must be stable and correct from the cycle after tx_start and may not bubble.
    - On tx_valid & tx_ready: pop, byte_cnt++ (saturating at 2047).
    - If the popped byte was last: go to END when byte_cnt+1 ≥ MIN_LEN, else go to PAD. Decrement the committed count either way.
  - PAD: tx_valid=1, tx_data=0x00. Each consume increments byte_cnt. Go to END on the consume that makes byte_cnt == MIN_LEN.
  - END: tx_valid=0 for this cycle and until tx_ready is seen low. Load holdoff = HOLDOFF, increment frames_sent, go to IDLE.
- Holdoff: counts down one per clock in IDLE and saturates at 0. With HOLDOFF=17 the earliest next tx_start is 17 clocks after the first tx_valid=0 cycle. This matches the MAC's 4 FCS + 1 + 12 idle cycles.
- tx_ready may be low for any number of cycles before the first consume. tx_valid is held high through those cycles.
- Ingress writes continue unaffected during SEND, PAD, END and holdoff.

Test Plan:
- One 64-byte frame (bytes 0x00..0x3F), MAC model attached → tx_start one pulse; 64 consumes carrying 0x00..0x3F in order; tx_valid low the next cycle; frames_sent=1.
- One 10-byte frame 0xA0..0xA9 → 10 data bytes, then 50 bytes of 0x00; total 60 consumes; then tx_valid=0.
- Two 60-byte frames written back-to-back → second tx_start occurs exactly 17 clocks after the first frame's tx_valid-low cycle; no start is lost; frames_sent=2.
- 2100-byte frame with no earlier committed frame → in_ready stays 1; frame discarded; frames_dropped=1; no tx_start. A following 60-byte frame is transmitted intact.
- FIFO holding one committed 1500-byte frame while a second frame is being written until full → in_ready=0 until reads free space; both frames are transmitted byte-exact.
- Assert rst during SEND of a 100-byte frame at byte 40 → next cycle tx_valid=0, in_ready=1, committed count 0; a subsequent 60-byte frame is transmitted correctly.

Source files
------------

// File: rtl/eth_tx_frame_feeder.sv
// eth_tx_frame_feeder
//   Store-and-forward byte FIFO feeding the RGMII transmit MAC. Ingress bytes are
//   committed a whole frame at a time. The tx FSM then replays each committed
//   frame using a start/ready/valid handshake. Short frames are zero-padded up to
//   MIN_LEN bytes. The next start is held off for HOLDOFF clocks after each frame.
//
// Ports
//   clk, rst        tx clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last   ingress byte stream
//   tx_start        one-cycle start strobe to the MAC
//   tx_ready        MAC accept; a byte is consumed on tx_valid & tx_ready
//   tx_valid/tx_data  byte towards the MAC; valid falling ends the frame
//   tx_error        abort request, tied low
//   frames_sent     wrapping count of completed frames
//   frames_dropped  wrapping count of frames discarded on overflow
module eth_tx_frame_feeder #(
   parameter int unsigned FIFO_AW = 11,
   parameter int unsigned MIN_LEN = 60,
   parameter int unsigned HOLDOFF = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        tx_start,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic        tx_error,
   output logic [7:0]  tx_data,
   output logic [15:0] frames_sent,
   output logic [15:0] frames_dropped
);

   localparam int unsigned Depth = 2 ** FIFO_AW;
   localparam int unsigned PtrW  = FIFO_AW + 1;
   localparam int unsigned HoW   = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [11:0]    MinLen    = 12'(MIN_LEN);
   localparam logic [HoW-1:0] HoldoffLd = HoW'(HOLDOFF);

   typedef enum logic [1:0] {StIdle, StSend, StPad, StEnd} state_e;

   state_e          state_q, state_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] committed_q, committed_d;
   logic            drop_q, drop_d;
   logic [15:0]     sent_q, sent_d, dropped_q, dropped_d;
   logic [10:0]     byte_cnt_q, byte_cnt_d;
   logic [HoW-1:0]  holdoff_q, holdoff_d;

   // Each entry carries the byte plus its end-of-frame flag.
   logic [8:0] mem [Depth];
   logic [8:0] head;
   logic       full, wr_en, mem_we, commit, consume, pop_last;
   logic [11:0] byte_cnt_inc;
   logic [10:0] byte_cnt_sat;

   assign full = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   // A full FIFO with nothing committed can never drain, so keep accepting and drop.
   assign in_ready = drop_q | ~full | (committed_q == '0);
   assign wr_en    = in_valid & in_ready;
   assign mem_we   = wr_en & ~drop_q & ~full;
   assign commit   = mem_we & in_last;

   assign head     = mem[rd_ptr_q[FIFO_AW-1:0]];
   assign tx_valid = (state_q == StSend) || (state_q == StPad);
   assign tx_data  = (state_q == StSend) ? head[7:0] : 8'h00;
   assign tx_error = 1'b0;
   assign consume  = tx_valid & tx_ready;
   assign pop_last = consume & (state_q == StSend) & head[8];

   assign byte_cnt_inc = {1'b0, byte_cnt_q} + 12'd1;
   assign byte_cnt_sat = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 11'd1;

   assign frames_sent    = sent_q;
   assign frames_dropped = dropped_q;

   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr_q[FIFO_AW-1:0]] <= {in_last, in_data};
   end

   // Ingress: write pointer, commit pointer and drop mode.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      drop_d       = drop_q;
      dropped_d    = dropped_q;
      if (wr_en) begin
         if (drop_q) begin
            if (in_last) begin
               drop_d    = 1'b0;
               dropped_d = dropped_q + 16'd1;
            end
         end else if (full) begin
            wr_ptr_d = commit_ptr_q;
            if (in_last) dropped_d = dropped_q + 16'd1;
            else         drop_d    = 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (in_last) commit_ptr_d = wr_ptr_q + PtrW'(1);
         end
      end
   end

   always_comb begin
      committed_d = committed_q;
      if (commit && !pop_last)      committed_d = committed_q + PtrW'(1);
      else if (!commit && pop_last) committed_d = committed_q - PtrW'(1);
   end

   // Tx FSM.
   always_comb begin
      state_d    = state_q;
      tx_start   = 1'b0;
      rd_ptr_d   = rd_ptr_q;
      byte_cnt_d = byte_cnt_q;
      sent_d     = sent_q;
      holdoff_d  = (holdoff_q != '0) ? holdoff_q - HoW'(1) : holdoff_q;
      unique case (state_q)
         StIdle: begin
            if (committed_q != '0 && holdoff_q == '0) begin
               tx_start   = 1'b1;
               byte_cnt_d = '0;
               state_d    = StSend;
            end
         end
         StSend: begin
            if (consume) begin
               rd_ptr_d   = rd_ptr_q + PtrW'(1);
               byte_cnt_d = byte_cnt_sat;
               if (head[8]) begin
                  if (byte_cnt_inc >= MinLen) begin
                     state_d   = StEnd;
                     // The first valid-low cycle already counts as holdoff clock one.
                     holdoff_d = HoldoffLd;
                  end else begin
                     state_d = StPad;
                  end
               end
            end
         end
         StPad: begin
            if (consume) begin
               byte_cnt_d = byte_cnt_sat;
               if (byte_cnt_inc >= MinLen) begin
                  state_d   = StEnd;
                  holdoff_d = HoldoffLd;
               end
            end
         end
         StEnd: begin
            if (!tx_ready) begin
               sent_d  = sent_q + 16'd1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         committed_q  <= '0;
         drop_q       <= 1'b0;
         sent_q       <= '0;
         dropped_q    <= '0;
         byte_cnt_q   <= '0;
         holdoff_q    <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         committed_q  <= committed_d;
         drop_q       <= drop_d;
         sent_q       <= sent_d;
         dropped_q    <= dropped_d;
         byte_cnt_q   <= byte_cnt_d;
         holdoff_q    <= holdoff_d;
      end
   end

endmodule

// File: tb/tb_eth_tx_frame_feeder.sv
module tb_eth_tx_frame_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic        in_last = 1'b0;
   logic        tx_start;
   logic        tx_ready = 1'b0;
   logic        tx_valid;
   logic        tx_error;
   logic [7:0]  tx_data;
   logic [15:0] frames_sent;
   logic [15:0] frames_dropped;

   always #5 clk = ~clk;

   eth_tx_frame_feeder dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_last        (in_last),
      .tx_start       (tx_start),
      .tx_ready       (tx_ready),
      .tx_valid       (tx_valid),
      .tx_error       (tx_error),
      .tx_data        (tx_data),
      .frames_sent    (frames_sent),
      .frames_dropped (frames_dropped)
   );

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   int len_q[$];
   int gap_q[$];
   int n_start = 0, cur_cnt = 0, cyc = 0, end_cyc = 0;
   bit in_frame = 0, have_end = 0, v_prev = 0;
   int ifg = 0, stall = 0, stalls = 0;
   bit mac_hold = 0;

   function automatic void check(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endfunction

   // MAC model and output monitor share one process so tx_ready is updated
   // before the monitor decides whether a byte is being consumed.
   initial begin : mac_and_monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            ifg = 0;
            stall = 0;
         end else begin
            if (tx_start) stall = 2;
            else if (stall > 0) stall--;
            if (v_prev && !tx_valid) ifg = 16;
            else if (ifg > 0) ifg--;
         end
         tx_ready = !mac_hold && ifg == 0 && stall == 0;

         if (rst) begin
            in_frame = 0;
            have_end = 0;
            v_prev   = 0;
         end else begin
            if (tx_start) begin
               n_start++;
               cur_cnt  = 0;
               in_frame = 1;
               if (have_end) begin
                  gap_q.push_back(cyc - end_cyc);
                  check("holdoff_gap_min", int'((cyc - end_cyc) >= 17), 1);
               end
            end
            if (tx_valid && tx_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_byte: got %0d want none", tx_data);
               end else begin
                  check("tx_byte", int'(tx_data), exp_q.pop_front());
               end
               cur_cnt++;
            end
            if (v_prev && !tx_valid && in_frame) begin
               if (len_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_frame_end: got len %0d want none", cur_cnt);
               end else begin
                  check("frame_len", cur_cnt, len_q.pop_front());
               end
               in_frame = 0;
               end_cyc  = cyc;
               have_end = 1;
            end
            v_prev = tx_valid;
         end
      end
   end

   task automatic put(input logic [7:0] d, input logic last);
      int t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && t < 10000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL ingress_timeout: in_ready=%0d want 1", in_ready);
      end
      stalls += t;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input int len, input int base, input bit expect_tx);
      if (expect_tx) begin
         for (int i = 0; i < len; i++) exp_q.push_back((base + i) & 255);
         for (int i = len; i < 60; i++) exp_q.push_back(0);
         len_q.push_back((len < 60) ? 60 : len);
      end
      for (int i = 0; i < len; i++) put(8'((base + i) & 255), i == len - 1);
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((exp_q.size() != 0 || tx_valid || in_frame) && t < 20000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 20000) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: pending=%0d want 0", exp_q.size());
      end
      repeat (25) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: sim time exceeded, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin : main
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_error", tx_error, 0);
      check("rst_frames_sent", frames_sent, 0);
      check("rst_frames_dropped", frames_dropped, 0);
      rst = 1'b0;

      // 64-byte frame, no padding
      send_frame(64, 8'h00, 1);
      wait_idle();
      check("t1_frames_sent", frames_sent, 1);
      check("t1_starts", n_start, 1);

      // 10-byte frame padded to 60
      send_frame(10, 8'hA0, 1);
      wait_idle();
      check("t2_frames_sent", frames_sent, 2);

      // back-to-back frames: holdoff-limited restart
      gap_q.delete();
      send_frame(60, 8'h10, 1);
      send_frame(60, 8'h80, 1);
      wait_idle();
      check("t3_gaps", gap_q.size(), 2);
      if (gap_q.size() == 2) check("t3_gap_exact", gap_q[1], 17);
      check("t3_frames_sent", frames_sent, 4);
      check("t3_starts", n_start, 4);

      // oversize frame with nothing committed is dropped, then normal traffic
      stalls = 0;
      send_frame(2100, 8'h21, 0);
      check("t4_no_stall", stalls, 0);
      check("t4_frames_dropped", frames_dropped, 1);
      check("t4_no_start", n_start, 4);
      send_frame(60, 8'h33, 1);
      wait_idle();
      check("t4_frames_sent", frames_sent, 5);
      check("t4_starts", n_start, 5);

      // fill the FIFO behind a committed frame while the MAC is stalled
      mac_hold = 1;
      stalls = 0;
      fork
         begin
            send_frame(1500, 8'h00, 1);
            send_frame(1000, 8'h55, 1);
         end
         begin
            int t = 0;
            while (in_ready && t < 5000) begin
               @(posedge clk);
               #1;
               t++;
            end
            check("t5_full_stall", in_ready, 0);
            repeat (10) @(posedge clk);
            #1;
            check("t5_stall_held", in_ready, 0);
            mac_hold = 0;
         end
      join
      wait_idle();
      check("t5_stalled", int'(stalls > 0), 1);
      check("t5_frames_sent", frames_sent, 7);

      // reset in the middle of a frame
      send_frame(100, 8'h40, 1);
      begin
         int t = 0;
         while (cur_cnt < 40 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
         end
         check("t6_reached_40", int'(cur_cnt >= 40), 1);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_tx_valid", tx_valid, 0);
      check("t6_in_ready", in_ready, 1);
      check("t6_frames_sent", frames_sent, 0);
      rst = 1'b0;
      exp_q.delete();
      len_q.delete();
      repeat (30) @(posedge clk);
      #1;
      check("t6_no_restart", tx_valid, 0);
      send_frame(60, 8'hC0, 1);
      wait_idle();
      check("t6_frames_sent_after", frames_sent, 1);
      check("t6_frames_dropped", frames_dropped, 0);
      check("end_queue_empty", exp_q.size(), 0);
      check("end_tx_error", tx_error, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
